// File: rtl/cr16_pkg.sv
// cr16_pkg
// Shared definitions for the pipelined CR16 datapath and its ALU.
// Contents:
//   - cr16_op_e     : ALU opcode encoding (values 8..15 are reserved NOPs)
//   - FLAGS_W       : width of the flags word
//   - FLAG_*        : bit positions inside the flags word {C,L,F,Z,N}
//   - op_is_valid() : opcode is one of the defined operations
//   - op_writes()   : opcode produces a register result
package cr16_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_CMP = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_MOV = 4'd6,
    OP_LSH = 4'd7
  } cr16_op_e;

  localparam int FLAGS_W = 5;
  localparam int FLAG_C  = 4;
  localparam int FLAG_L  = 3;
  localparam int FLAG_F  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 0;

  // Opcodes 8..15 all have the top bit set and are reserved.
  function automatic logic op_is_valid(input logic [3:0] op);
    return !op[3];
  endfunction

  // CMP only sets flags; reserved opcodes do nothing at all.
  function automatic logic op_writes(input logic [3:0] op);
    return !op[3] && (op != 4'(OP_CMP));
  endfunction

endpackage

// File: rtl/cr16_alu_param.sv
// cr16_alu_param
// Purely combinational, WIDTH-parametrised CR16 ALU.
// Ports:
//   a       in  WIDTH    source A
//   b       in  WIDTH    source B (register or immediate, chosen upstream)
//   opcode  in  4        operation (cr16_op_e, 8..15 reserved)
//   result  out WIDTH    operation result (modulo 2^WIDTH)
//   flags   out FLAGS_W  {C,L,F,Z,N} produced by this operation
//   writes  out 1        operation produces a register result
//   valid   out 1        opcode is a defined operation
module cr16_alu_param
  import cr16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         opcode,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags,
  output logic               writes,
  output logic               valid
);

  localparam int MSB = WIDTH - 1;

  // One extra bit on the adder/subtractor exposes carry and borrow directly.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  // Shift distance is B[4:0] as a signed value; the magnitude of -16 needs 6 bits.
  logic [5:0]       sh_ext;
  logic [5:0]       sh_mag;
  logic [WIDTH-1:0] shifted;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign sh_ext = {b[4], b[4:0]};
  assign sh_mag = b[4] ? (6'd0 - sh_ext) : sh_ext;

  // Positive distances shift left, negative shift logically right, and any
  // distance that moves every bit out produces zero.
  always_comb begin
    shifted = '0;
    if (32'(sh_mag) < WIDTH) begin
      if (b[4]) begin
        shifted = a >> sh_mag;
      end else begin
        shifted = a << sh_mag;
      end
    end
  end

  always_comb begin
    result = '0;
    flags  = '0;
    case (opcode)
      OP_ADD: begin
        result         = sum[MSB:0];
        flags[FLAG_C]  = sum[WIDTH];
        flags[FLAG_F]  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        flags[FLAG_Z]  = (sum[MSB:0] == '0);
        flags[FLAG_N]  = sum[MSB];
      end
      OP_SUB, OP_CMP: begin
        // N reports the signed comparison rather than the result sign, so
        // it stays correct when the subtraction overflows.
        result         = diff[MSB:0];
        flags[FLAG_C]  = diff[WIDTH];
        flags[FLAG_L]  = (a < b);
        flags[FLAG_F]  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        flags[FLAG_Z]  = (a == b);
        flags[FLAG_N]  = ($signed(a) < $signed(b));
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = b;
      OP_LSH: result = shifted;
      default: result = '0;
    endcase
    // Logic, move and shift only report zero and sign of the result.
    if (opcode inside {OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH}) begin
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[MSB];
    end
  end

  assign writes = op_writes(opcode);
  assign valid  = op_is_valid(opcode);

endmodule

// File: rtl/cr16_datapath_pipe.sv
// cr16_datapath_pipe
// Two-stage (EX -> WB) pipelined CR16 datapath: register file, operand
// selection with immediate substitution, ALU, flags register and a
// registered write-back stage. Operations are accepted on I_VALID && O_READY
// and commit to the register file/flags at the end of the following cycle.
//
// Build option: CR16_DATAPATH_FORWARDING_EN
//   defined   - WB result is bypassed into EX operands, O_READY = !I_RESET
//   undefined - no bypass; O_READY drops for one cycle on a RAW hazard
//
// Ports:
//   I_CLK, I_RESET     clock (rising edge) and async active-high reset
//   I_VALID / O_READY  operation handshake
//   I_OPCODE           ALU operation
//   I_RA_SEL           destination and source A register
//   I_RB_SEL           source B register
//   I_IMMEDIATE        immediate operand, used as B when I_IMM_SEL = 1
//   I_WB_EN            request register write of the result
//   I_FLAGS_EN         request flags update
//   O_WB_VALID         write-back stage holds an operation
//   O_WB_SEL/O_WB_DATA write-back destination and result
//   O_FLAGS            flags register {C,L,F,Z,N}
//   I_DBG_SEL          debug read select
//   O_DBG_DATA         committed register contents, combinational
module cr16_datapath_pipe
  import cr16_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int NUM_REGS = 16,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_VALID,
  output logic               O_READY,
  input  logic [3:0]         I_OPCODE,
  input  logic [SEL_W-1:0]   I_RA_SEL,
  input  logic [SEL_W-1:0]   I_RB_SEL,
  input  logic [WIDTH-1:0]   I_IMMEDIATE,
  input  logic               I_IMM_SEL,
  input  logic               I_WB_EN,
  input  logic               I_FLAGS_EN,
  output logic               O_WB_VALID,
  output logic [SEL_W-1:0]   O_WB_SEL,
  output logic [WIDTH-1:0]   O_WB_DATA,
  output logic [FLAGS_W-1:0] O_FLAGS,
  input  logic [SEL_W-1:0]   I_DBG_SEL,
  output logic [WIDTH-1:0]   O_DBG_DATA
);

  // Architectural state
  logic [WIDTH-1:0]   regs_q [NUM_REGS];
  logic [WIDTH-1:0]   regs_d [NUM_REGS];
  logic [FLAGS_W-1:0] flags_q, flags_d;

  // Write-back pipeline register
  logic               wb_valid_q, wb_valid_d;
  logic [SEL_W-1:0]   wb_sel_q, wb_sel_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic               wb_we_q, wb_we_d;
  logic               wb_fe_q, wb_fe_d;
  logic [FLAGS_W-1:0] wb_flags_q, wb_flags_d;

  // EX stage
  logic [WIDTH-1:0]   reg_a, reg_b;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               haz_a, haz_b;
  logic               ready;
  logic               accept;
  logic [WIDTH-1:0]   alu_result;
  logic [FLAGS_W-1:0] alu_flags;
  logic               alu_writes;
  logic               alu_valid;

  assign reg_a = regs_q[I_RA_SEL];
  assign reg_b = regs_q[I_RB_SEL];

  // A source collides with the in-flight result only if WB will really write
  // it; B is irrelevant when the immediate replaces it.
  assign haz_a = wb_valid_q && wb_we_q && (wb_sel_q == I_RA_SEL);
  assign haz_b = wb_valid_q && wb_we_q && (wb_sel_q == I_RB_SEL) && !I_IMM_SEL;

`ifdef CR16_DATAPATH_FORWARDING_EN
  assign op_a  = haz_a ? wb_data_q : reg_a;
  assign op_b  = I_IMM_SEL ? I_IMMEDIATE : (haz_b ? wb_data_q : reg_b);
  assign ready = !I_RESET;
`else
  // Without a bypass the producer holds the operation for one cycle while
  // the conflicting result commits; the next cycle reads the updated file.
  assign op_a  = reg_a;
  assign op_b  = I_IMM_SEL ? I_IMMEDIATE : reg_b;
  assign ready = !I_RESET && !(I_VALID && (haz_a || haz_b));
`endif

  assign accept = I_VALID && ready;

  cr16_alu_param #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .opcode (I_OPCODE),
    .result (alu_result),
    .flags  (alu_flags),
    .writes (alu_writes),
    .valid  (alu_valid)
  );

  // Pipeline register next state: a non-accepted cycle becomes a bubble;
  // payload fields simply hold since nothing uses them without valid.
  always_comb begin
    wb_valid_d = accept;
    wb_sel_d   = wb_sel_q;
    wb_data_d  = wb_data_q;
    wb_we_d    = wb_we_q;
    wb_fe_d    = wb_fe_q;
    wb_flags_d = wb_flags_q;
    if (accept) begin
      wb_sel_d   = I_RA_SEL;
      wb_data_d  = alu_result;
      wb_we_d    = I_WB_EN && alu_writes;
      wb_fe_d    = I_FLAGS_EN && alu_valid;
      wb_flags_d = alu_flags;
    end
  end

  // Commit at the closing edge of the WB cycle.
  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    if (wb_valid_q && wb_we_q) begin
      regs_d[wb_sel_q] = wb_data_q;
    end
    if (wb_valid_q && wb_fe_q) begin
      flags_d = wb_flags_q;
    end
  end

  // Reset wipes the in-flight operation together with the architectural
  // state, so an interrupted write never lands.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      wb_fe_q    <= 1'b0;
      wb_flags_q <= '0;
    end else begin
      regs_q     <= regs_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
      wb_fe_q    <= wb_fe_d;
      wb_flags_q <= wb_flags_d;
    end
  end

  assign O_READY    = ready;
  assign O_WB_VALID = wb_valid_q;
  assign O_WB_SEL   = wb_sel_q;
  assign O_WB_DATA  = wb_data_q;
  assign O_FLAGS    = flags_q;
  assign O_DBG_DATA = regs_q[I_DBG_SEL];

endmodule

// File: tb/tb_cr16_datapath_pipe.sv
// Directed bench for cr16_datapath_pipe (WIDTH=16, NUM_REGS=16).
// Works for both builds: stall expectations follow CR16_DATAPATH_FORWARDING_EN.
module tb_cr16_datapath_pipe;

   logic        I_CLK = 1'b0;
   logic        I_RESET;
   logic        I_VALID;
   logic        O_READY;
   logic [3:0]  I_OPCODE;
   logic [3:0]  I_RA_SEL;
   logic [3:0]  I_RB_SEL;
   logic [15:0] I_IMMEDIATE;
   logic        I_IMM_SEL;
   logic        I_WB_EN;
   logic        I_FLAGS_EN;
   logic        O_WB_VALID;
   logic [3:0]  O_WB_SEL;
   logic [15:0] O_WB_DATA;
   logic [4:0]  O_FLAGS;
   logic [3:0]  I_DBG_SEL;
   logic [15:0] O_DBG_DATA;

   int passCount  = 0;
   int totalCount = 0;
   int lastStalls = 0;
   int expStalls;

   cr16_datapath_pipe #(
      .WIDTH    (16),
      .NUM_REGS (16)
   ) dut (
      .I_CLK       (I_CLK),
      .I_RESET     (I_RESET),
      .I_VALID     (I_VALID),
      .O_READY     (O_READY),
      .I_OPCODE    (I_OPCODE),
      .I_RA_SEL    (I_RA_SEL),
      .I_RB_SEL    (I_RB_SEL),
      .I_IMMEDIATE (I_IMMEDIATE),
      .I_IMM_SEL   (I_IMM_SEL),
      .I_WB_EN     (I_WB_EN),
      .I_FLAGS_EN  (I_FLAGS_EN),
      .O_WB_VALID  (O_WB_VALID),
      .O_WB_SEL    (O_WB_SEL),
      .O_WB_DATA   (O_WB_DATA),
      .O_FLAGS     (O_FLAGS),
      .I_DBG_SEL   (I_DBG_SEL),
      .O_DBG_DATA  (O_DBG_DATA)
   );

   // 10-time-unit clock; outputs are sampled around the falling edge.
   always #5 I_CLK = ~I_CLK;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      totalCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one operation from a falling edge, holds it until accepted
   // (counting stall cycles), and returns at the falling edge of the WB cycle.
   task automatic applyStimulus(input logic [3:0] op, input int ra, input int rb,
                                input logic [15:0] imm, input logic immSel,
                                input logic we, input logic fe);
      logic accepted;
      I_OPCODE    = op;
      I_RA_SEL    = ra[3:0];
      I_RB_SEL    = rb[3:0];
      I_IMMEDIATE = imm;
      I_IMM_SEL   = immSel;
      I_WB_EN     = we;
      I_FLAGS_EN  = fe;
      I_VALID     = 1'b1;
      lastStalls  = 0;
      accepted    = 1'b0;
      for (int n = 0; n < 5; n++) begin
         #1;
         if (O_READY) begin
            accepted = 1'b1;
            break;
         end
         lastStalls++;
         @(negedge I_CLK);
      end
      checkOutput("acceptWithinBudget", {31'd0, accepted}, 32'd1);
      @(posedge I_CLK);
      @(negedge I_CLK);
      I_VALID = 1'b0;
   endtask

   task automatic idleCycle();
      @(negedge I_CLK);
   endtask

   task automatic checkReg(input string tag, input int idx, input logic [15:0] exp);
      I_DBG_SEL = idx[3:0];
      #1;
      checkOutput(tag, {16'd0, O_DBG_DATA}, {16'd0, exp});
   endtask

   initial begin
`ifdef CR16_DATAPATH_FORWARDING_EN
      expStalls = 0;
`else
      expStalls = 1;
`endif
      I_RESET = 1'b1; I_VALID = 1'b0; I_OPCODE = '0; I_RA_SEL = '0; I_RB_SEL = '0;
      I_IMMEDIATE = '0; I_IMM_SEL = 1'b0; I_WB_EN = 1'b0; I_FLAGS_EN = 1'b0; I_DBG_SEL = '0;

      // Reset state
      repeat (2) @(negedge I_CLK);
      checkOutput("resetReady", {31'd0, O_READY}, 32'd0);
      checkOutput("resetWbValid", {31'd0, O_WB_VALID}, 32'd0);
      checkOutput("resetWbSel", {28'd0, O_WB_SEL}, 32'd0);
      checkOutput("resetWbData", {16'd0, O_WB_DATA}, 32'd0);
      checkOutput("resetFlags", {27'd0, O_FLAGS}, 32'd0);
      checkReg("resetR5", 5, 16'h0000);
      I_RESET = 1'b0;
      #1;
      checkOutput("readyAfterReset", {31'd0, O_READY}, 32'd1);
      idleCycle();

      // ADD r1 = r0 + 5
      applyStimulus(4'd0, 1, 0, 16'd5, 1'b1, 1'b1, 1'b1);
      checkOutput("addWbValid", {31'd0, O_WB_VALID}, 32'd1);
      checkOutput("addWbSel", {28'd0, O_WB_SEL}, 32'd1);
      checkOutput("addWbData", {16'd0, O_WB_DATA}, 32'd5);
      idleCycle();
      checkReg("addR1", 1, 16'd5);
      checkOutput("addFlags", {27'd0, O_FLAGS}, 32'h00);
      checkOutput("bubbleWbValid", {31'd0, O_WB_VALID}, 32'd0);

      // Back-to-back dependency: r1 = 3, then r1 = r1 + 4
      applyStimulus(4'd6, 1, 0, 16'd3, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd0, 1, 0, 16'd4, 1'b1, 1'b1, 1'b1);
      checkOutput("rawStallsA", lastStalls, expStalls);
      checkOutput("rawWbData", {16'd0, O_WB_DATA}, 32'd7);
      idleCycle();
      checkReg("rawR1", 1, 16'd7);

      // Dependency through register B: r10 = 2, then r11 = r11 + r10
      applyStimulus(4'd6, 10, 0, 16'd2, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd0, 11, 10, 16'hDEAD, 1'b0, 1'b1, 1'b0);
      checkOutput("rawStallsB", lastStalls, expStalls);
      checkOutput("rawBWbData", {16'd0, O_WB_DATA}, 32'd2);
      idleCycle();

      // CMP r2(1) vs 0xFFFF: C=1 L=1, r2 untouched despite I_WB_EN
      applyStimulus(4'd6, 2, 0, 16'h0001, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd2, 2, 0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      idleCycle();
      checkOutput("cmpFlags", {27'd0, O_FLAGS}, 32'h18);
      checkReg("cmpR2", 2, 16'h0001);

      // Signed overflow and carry on ADD
      applyStimulus(4'd6, 4, 0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd0, 4, 0, 16'h0001, 1'b1, 1'b1, 1'b1);
      checkOutput("ovfWbData", {16'd0, O_WB_DATA}, 32'h8000);
      idleCycle();
      checkOutput("ovfFlags", {27'd0, O_FLAGS}, 32'h05);
      applyStimulus(4'd6, 5, 0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd0, 5, 0, 16'h0001, 1'b1, 1'b1, 1'b1);
      checkOutput("carryWbData", {16'd0, O_WB_DATA}, 32'h0000);
      idleCycle();
      checkOutput("carryFlags", {27'd0, O_FLAGS}, 32'h12);

      // SUB with register B: r9 = 5 - r1(7) = 0xFFFE
      applyStimulus(4'd6, 9, 0, 16'd5, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd1, 9, 1, 16'h0000, 1'b0, 1'b1, 1'b1);
      checkOutput("subWbData", {16'd0, O_WB_DATA}, 32'hFFFE);
      idleCycle();
      checkOutput("subFlags", {27'd0, O_FLAGS}, 32'h19);
      checkReg("subR9", 9, 16'hFFFE);

      // Logical right shift by -4, then shift out completely by -16
      applyStimulus(4'd6, 6, 0, 16'h0F00, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd7, 6, 0, 16'h001C, 1'b1, 1'b1, 1'b1);
      checkOutput("lshRightWbData", {16'd0, O_WB_DATA}, 32'h00F0);
      idleCycle();
      checkOutput("lshRightFlags", {27'd0, O_FLAGS}, 32'h00);
      applyStimulus(4'd6, 7, 0, 16'h0F00, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'd7, 7, 0, 16'h0010, 1'b1, 1'b1, 1'b1);
      checkOutput("lshOutWbData", {16'd0, O_WB_DATA}, 32'h0000);
      idleCycle();
      checkOutput("lshOutFlags", {27'd0, O_FLAGS}, 32'h02);

      // Reserved opcode: no register or flag change
      applyStimulus(4'd9, 7, 0, 16'h1234, 1'b1, 1'b1, 1'b1);
      idleCycle();
      idleCycle();
      checkReg("nopR7", 7, 16'h0000);
      checkOutput("nopFlags", {27'd0, O_FLAGS}, 32'h02);

      // Left shift by 4 sets N
      applyStimulus(4'd7, 6, 0, 16'h0004, 1'b1, 1'b1, 1'b1);
      checkOutput("lshLeftWbData", {16'd0, O_WB_DATA}, 32'h0F00);
      applyStimulus(4'd7, 6, 0, 16'h0004, 1'b1, 1'b1, 1'b1);
      checkOutput("lshLeft2WbData", {16'd0, O_WB_DATA}, 32'hF000);
      idleCycle();
      checkOutput("lshLeftFlags", {27'd0, O_FLAGS}, 32'h01);

      // Reset during the WB cycle of r3 = 0xAAAA
      I_OPCODE = 4'd6; I_RA_SEL = 4'd3; I_IMMEDIATE = 16'hAAAA; I_IMM_SEL = 1'b1;
      I_WB_EN = 1'b1; I_FLAGS_EN = 1'b0; I_VALID = 1'b1;
      @(posedge I_CLK);
      #1;
      checkOutput("midWbValidBefore", {31'd0, O_WB_VALID}, 32'd1);
      I_RESET = 1'b1;
      I_VALID = 1'b0;
      #1;
      checkOutput("midResetWbValid", {31'd0, O_WB_VALID}, 32'd0);
      checkOutput("midResetReady", {31'd0, O_READY}, 32'd0);
      repeat (2) @(negedge I_CLK);
      checkOutput("midResetReadyHeld", {31'd0, O_READY}, 32'd0);
      I_RESET = 1'b0;
      idleCycle();
      checkReg("midResetR3", 3, 16'h0000);
      checkOutput("midResetFlags", {27'd0, O_FLAGS}, 32'h00);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cr16_datapath_pipe.md
# cr16_datapath_pipe

Parametrised, two-stage pipelined successor of the CR16 single-cycle datapath: a `NUM_REGS` x `WIDTH` register file, operand selection with immediate substitution, an ALU, and a flags register, with a registered write-back stage. Operations enter through a valid/ready handshake, and results are written one cycle after acceptance. The block sits between the CR16 control/decode FSM and memory/IO, and is the datapath core for multi-cycle and pipelined control.

## Interface
Parameters:
- `WIDTH`, 16, data/register width (>= 8)
- `NUM_REGS`, 16, register count (power of two, >= 2)
- `SEL_W`, `$clog2(NUM_REGS)`, derived register-select width (localparam)

Ports:
- `I_CLK`  in  1  clock, all state on rising edge
- `I_RESET`  in  1  asynchronous, active-high reset
- `I_VALID`  in  1  operation present
- `O_READY`  out  1  operation accepted when `I_VALID && O_READY`
- `I_OPCODE`  in  4  ALU operation
- `I_RA_SEL`  in  SEL_W  destination and source A register
- `I_RB_SEL`  in  SEL_W  source B register
- `I_IMMEDIATE`  in  WIDTH  immediate operand
- `I_IMM_SEL`  in  1  1: B = `I_IMMEDIATE`; 0: B = reg[`I_RB_SEL`]
- `I_WB_EN`  in  1  write result to reg[`I_RA_SEL`]
- `I_FLAGS_EN`  in  1  update flags register
- `O_WB_VALID`  out  1  write-back stage holds an operation
- `O_WB_SEL`  out  SEL_W  write-back destination
- `O_WB_DATA`  out  WIDTH  write-back result
- `O_FLAGS`  out  5  flags register {C,L,F,Z,N}
- `I_DBG_SEL`  in  SEL_W  debug read select
- `O_DBG_DATA`  out  WIDTH  combinational reg[`I_DBG_SEL`], committed state only

## Operation
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 CMP: A-B, never writes a register
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV: B
  - 7 LSH: A shifted by signed B[4:0]; positive shifts left, negative shifts logical right, and a magnitude >= WIDTH yields 0
  - 8–15 reserved: NOP, no register or flag write
- Arithmetic is modulo 2^WIDTH.
- ADD flags:
  - C = carry out
  - F = signed overflow
  - Z = (result==0)
  - N = result MSB
  - L = 0
- SUB/CMP flags:
  - C = borrow
  - L = A<B unsigned
  - F = signed overflow
  - Z = (A==B)
  - N = A<B signed
- Logic/MOV/LSH flags: Z and N from the result; C, L and F cleared.
- Stage EX (acceptance cycle):
  - operands read, ALU evaluated
  - result, destination, effective write enable (`I_WB_EN` && opcode writes) and effective flag enable (`I_FLAGS_EN` && opcode valid) captured into the WB register
- Stage WB (next cycle): `O_WB_*` present the captured values; at the closing edge the register file and flags are updated if enabled.
- Operand read-after-write: a source equal to the in-flight WB destination with write enable takes `O_WB_DATA` (see Configuration).
- Not accepted: WB valid clears next cycle. This is a bubble with no writes.

## Timing
- Reset (async assert, sync-safe deassert):
  - all registers 0
  - `O_FLAGS`=0
  - `O_WB_VALID`=0, `O_WB_SEL`=0, `O_WB_DATA`=0
  - `O_READY`=0 while `I_RESET` high
- Reset mid-operation: the in-flight WB operation is discarded, with no register or flag write.
- Latency: accepted at edge N → `O_WB_VALID` during cycle N+1 → register and `O_DBG_DATA` visible from N+2.
- Throughput: one operation per cycle with forwarding.
- Back-to-back dependent operations see the forwarded value with no stall (forwarding build).

## Configuration
- `CR16_DATAPATH_FORWARDING_EN` defined:
  - WB→EX bypass on A and B (B only when `I_IMM_SEL`=0)
  - `O_READY` = !`I_RESET` constantly
- Undefined:
  - no bypass
  - `O_READY` deasserts for one cycle when `I_VALID` and WB holds a write to `I_RA_SEL`, or to `I_RB_SEL` with `I_IMM_SEL`=0
  - the operation is held by the producer and accepted the following cycle

## Structure
- Shared package `cr16_pkg`:
  - opcode enum/localparams
  - flag bit indices (C=4, L=3, F=2, Z=1, N=0)
- Sub-module `cr16_alu_param` (WIDTH-parametrised, combinational: A, B, opcode → result, flags, writes, valid).
- Register file, hazard/bypass logic and pipeline register stay in this module.

## Test plan
- Reset, then ADD r1 = r0 + imm 5 (`I_WB_EN`, `I_FLAGS_EN`) → `O_WB_VALID`, `O_WB_DATA`=5 next cycle; `O_DBG_DATA`(r1)=5 cycle after; flags Z=0, N=0.
- Back-to-back: r1=imm 3, then ADD r1 = r1 + imm 4 → second `O_WB_DATA`=7.
  - Forwarding build: no `O_READY` drop.
  - Non-forwarding build: exactly one `O_READY` low cycle.
- CMP r2(0x0001) vs imm 0xFFFF (WIDTH=16) → L=1, N=0, Z=0, C=1, r2 unchanged.
- ADD 0x7FFF + 1 → result 0x8000, F=1, N=1, C=0; then 0xFFFF + 1 → 0, C=1, Z=1.
- LSH 0x0F00 by imm 0x1C (-4) → 0x00F0; by imm 16 → 0; opcode 9 → no register or flag change.
- Assert `I_RESET` during WB of write r3=0xAAAA → r3 stays 0, `O_WB_VALID`=0 immediately, `O_READY`=0 until release.
